alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width.
REQ-002 Parameter MUL_CYCLES, default WIDTH, iterations of serial multiply, used only when ALU_MUL_EN is defined.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  unit can accept a request this cycle.
REQ-007 alu_op  input  4  ALU control code from the ALU control decoder.
REQ-008 src_a  input  WIDTH  operand A.
REQ-009 src_b  input  WIDTH  operand B.
REQ-010 out_valid  output  1  result registers hold an unconsumed result.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 result  output  WIDTH  registered result.
REQ-013 zero  output  1  registered, result == 0.
REQ-014 overflow  output  1  registered signed overflow for add/sub.
REQ-015 illegal_op  output  1  registered, alu_op not a supported code.
REQ-016 busy  output  1  multi-cycle operation in progress.

Function
REQ-017 Request accepted on a rising edge with in_valid && in_ready; operands and alu_op captured then.
REQ-018 in_ready = (state == IDLE) && (!out_valid || out_ready), combinational.
REQ-019 Codes: 0010 add, 0110 sub (A-B), 0000 and, 0001 or, 0111 slt, 1100 nor, 0011 xor, 1111 nop.
REQ-020 slt compares signed; result = {WIDTH-1 zeros, A<B}.
REQ-021 add/sub wrap modulo 2^WIDTH; overflow = operands' signs cause sign flip (add: same signs, result differs; sub: signs differ, result sign != A sign); overflow = 0 for all other codes.
REQ-022 nop: result 0, zero 1, overflow 0, illegal_op 0.
REQ-023 Any other code (and 1000 without ALU_MUL_EN): result 0, zero 1, overflow 0, illegal_op 1; still completes with one-cycle latency.
REQ-024 Single-cycle codes: accepted at edge N -> out_valid high and outputs valid after edge N (latency 1).
REQ-025 out_valid clears on edge where out_ready is high unless a new result is loaded that same edge; back-to-back accept with out_ready held high sustains one result per cycle.
REQ-026 result/zero/overflow/illegal_op stay stable while out_valid && !out_ready.
REQ-027 FSM states: IDLE, MUL (only with ALU_MUL_EN); IDLE->MUL on accepting 1000; MUL->IDLE after MUL_CYCLES iterations, loading outputs and setting out_valid on that edge.
REQ-028 busy = (state == MUL); in_ready = 0 while busy.
REQ-029 Inputs changing while not accepted are ignored.

Reset
REQ-030 rst high: state IDLE, out_valid 0, result 0, zero 0, overflow 0, illegal_op 0, busy 0, multiply iteration counter 0, immediately and asynchronously.
REQ-031 rst during MUL aborts the operation; no result is ever delivered for it.
REQ-032 in_ready is 1 in the first cycle after rst deasserts.

Configuration
REQ-033 Macro ALU_MUL_EN defined: code 1000 = unsigned multiply, result = low WIDTH bits of A*B, shift-and-add, out_valid exactly MUL_CYCLES+1 edges after acceptance, overflow 0, illegal_op 0.
REQ-034 Macro ALU_MUL_EN undefined: no MUL state, no multiplier logic, busy tied 0, 1000 treated as illegal (REQ-023).

Structure
REQ-035 Package alu_pkg holds the 4-bit op code constants (ALU_AND, ALU_OR, ALU_XOR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_MUL, ALU_NOP) and the FSM state type, shared with the ALU control decoder.
REQ-036 Serial multiplier is sub-module alu_mul_serial (start, operands in; done, product out), instantiated only under ALU_MUL_EN.

Verification
REQ-037 add 0x7FFFFFFF + 0x00000001, out_ready=1 -> next cycle result 0x80000000, overflow 1, zero 0.
REQ-038 sub 5 - 5 -> result 0, zero 1, overflow 0; slt A=0xFFFFFFFF, B=1 -> result 1.
REQ-039 alu_op 0101 -> result 0, illegal_op 1, out_valid after 1 cycle; nor 0,0 -> 0xFFFFFFFF.
REQ-040 Backpressure: out_ready=0 after a result -> in_ready 0, outputs stable 5 cycles; out_ready=1 with new in_valid -> new result next edge, no loss.
REQ-041 ALU_MUL_EN: 1000 with A=6, B=7 -> busy for 32 cycles, result 42 at cycle 33; in_ready 0 throughout.
REQ-042 rst asserted mid-multiply at cycle 10 -> out_valid 0, busy 0 immediately; next request executes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: op codes and FSM state type shared by alu_exec and the ALU control decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  // 4-bit ALU control codes as produced by the ALU control decoder
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  // Execution unit state; MUL is only reachable when ALU_MUL_EN is defined
  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_exec_if.sv
// alu_exec_if: request/result handshake bundle for alu_exec.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
// Ports: master = requester/consumer (drives request + out_ready), slave = alu_exec.
interface alu_exec_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal_op;
  logic             busy;

  modport master (
    output in_valid, alu_op, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, overflow, illegal_op, busy
  );

  modport slave (
    input  in_valid, alu_op, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, overflow, illegal_op, busy
  );
endinterface

// File: rtl/alu_mul_serial.sv
// alu_mul_serial: unsigned shift-and-add multiplier, low WIDTH bits of a*b.
// Latency: start captured on edge N, done high after edge N+MUL_CYCLES, cleared on the following edge.
// Backpressure: none; the caller must consume product on the cycle done is high.
// Ports: clk, rst (async active-high), start, a, b in; done, product out.
module alu_mul_serial #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(MUL_CYCLES + 1);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             running;

  assign done    = running && (cnt == CW'(MUL_CYCLES));
  assign product = acc;

  // One multiplier bit per cycle, LSB first; the multiplicand shifts left in step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      acc     <= '0;
      mcand   <= a;
      mplier  <= b;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (done) begin
        running <= 1'b0;
      end else begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_exec.sv
// alu_exec: registered integer ALU (add/sub/logic/slt, optional serial multiply).
// Latency: 1 cycle for single-cycle codes; MUL_CYCLES+1 cycles for multiply.
// Backpressure: in_ready drops while a result is held unconsumed or a multiply runs.
// Ports: clk, rst (async active-high), bus (alu_exec_if.slave).
// Config: define ALU_MUL_EN to enable code 1000 as unsigned multiply; otherwise 1000 is illegal.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = WIDTH
) (
  input logic        clk,
  input logic        rst,
  alu_exec_if.slave  bus
);
  logic [WIDTH-1:0] a, b;
  logic [WIDTH-1:0] sum, diff;
  logic [WIDTH-1:0] calc_res;
  logic             calc_ovf, calc_ill;
  logic             accept, in_ready_int, busy_int;
  logic             ld_en, ld_ovf, ld_ill;
  logic [WIDTH-1:0] ld_res;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, overflow_q, illegal_q;

  assign a      = bus.src_a;
  assign b      = bus.src_b;
  assign sum    = a + b;
  assign diff   = a - b;
  assign accept = bus.in_valid && in_ready_int;

  // Single-cycle datapath
  always_comb begin
    calc_res = '0;
    calc_ovf = 1'b0;
    calc_ill = 1'b0;
    case (bus.alu_op)
      ALU_ADD: begin
        calc_res = sum;
        // same-sign operands producing a differently-signed sum
        calc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        calc_res = diff;
        calc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: calc_res = a & b;
      ALU_OR:  calc_res = a | b;
      ALU_XOR: calc_res = a ^ b;
      ALU_NOR: calc_res = ~(a | b);
      ALU_SLT: calc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_NOP: calc_res = '0;
`ifdef ALU_MUL_EN
      ALU_MUL: calc_res = '0;  // result comes from the serial multiplier
`endif
      default: calc_ill = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  alu_state_t       state, state_nxt;
  logic             is_mul, mul_start, mul_done;
  logic [WIDTH-1:0] mul_product;

  assign is_mul    = (bus.alu_op == ALU_MUL);
  assign mul_start = accept && is_mul;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mul_start) state_nxt = MUL;
      MUL:     if (mul_done)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready_int = (state == IDLE) && (!out_valid_q || bus.out_ready);
  assign busy_int     = (state == MUL);

  alu_mul_serial #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    ld_en  = 1'b0;
    ld_res = calc_res;
    ld_ovf = calc_ovf;
    ld_ill = calc_ill;
    if (accept && !is_mul) begin
      ld_en = 1'b1;
    end else if (mul_done) begin
      // no request can be accepted while MUL runs, so this never collides with the branch above
      ld_en  = 1'b1;
      ld_res = mul_product;
      ld_ovf = 1'b0;
      ld_ill = 1'b0;
    end
  end
`else
  assign in_ready_int = !out_valid_q || bus.out_ready;
  assign busy_int     = 1'b0;

  always_comb begin
    ld_en  = accept;
    ld_res = calc_res;
    ld_ovf = calc_ovf;
    ld_ill = calc_ill;
  end
`endif

  // Output registers: loading a new result takes priority over the consume-clear,
  // which is what lets back-to-back requests stream at one per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (ld_en) begin
      out_valid_q <= 1'b1;
      result_q    <= ld_res;
      zero_q      <= (ld_res == '0);
      overflow_q  <= ld_ovf;
      illegal_q   <= ld_ill;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready   = in_ready_int;
  assign bus.busy       = busy_int;
  assign bus.out_valid  = out_valid_q;
  assign bus.result     = result_q;
  assign bus.zero       = zero_q;
  assign bus.overflow   = overflow_q;
  assign bus.illegal_op = illegal_q;
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed corner cases plus randomized stream against a reference model.
// Latency: n/a.
// Backpressure: randomized out_ready in the stream phase.
module tb_alu_exec;
  import alu_pkg::*;

  localparam int W    = 32;
  localparam int MULC = 32;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         o;
    logic         i;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_exec_if #(.WIDTH(W)) bus ();

  alu_exec #(
    .WIDTH      (W),
    .MUL_CYCLES (MULC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit mul_code(input logic [3:0] op);
`ifdef ALU_MUL_EN
    return op == ALU_MUL;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: plain integer arithmetic on the op code meanings
  function automatic exp_t ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t            e;
    longint          sa, sb, s;
    longint unsigned p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e  = '0;
    case (op)
      4'b0010: begin s = sa + sb; e.res = s[W-1:0]; e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'b0110: begin s = sa - sb; e.res = s[W-1:0]; e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0011: e.res = a ^ b;
      4'b1100: e.res = ~(a | b);
      4'b0111: e.res = (sa < sb) ? 1 : 0;
      4'b1111: e.res = 0;
      4'b1000: begin
        if (mul_code(op)) begin
          p = 64'(a) * 64'(b);
          e.res = p[W-1:0];
        end else begin
          e.i = 1'b1;
        end
      end
      default: e.i = 1'b1;
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h7fffffff;
      2:       return 32'h80000000;
      3:       return 32'hffffffff;
      4:       return W'($urandom_range(0, 7));
      default: return W'($urandom());
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic ez, input logic eo, input logic ei, input int elat);
    int lat;
    bit bad;
    bus.alu_op    = op;
    bus.src_a     = a;
    bus.src_b     = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check({tag, " in_ready"}, bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    bad = 0;
    while (!bus.out_valid && lat < 200) begin
      if (!bus.busy || bus.in_ready) bad = 1;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, elat);
    check({tag, " busy_hold"}, bad, 0);
    check({tag, " result"}, bus.result, er);
    check({tag, " zero"}, bus.zero, ez);
    check({tag, " overflow"}, bus.overflow, eo);
    check({tag, " illegal"}, bus.illegal_op, ei);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t sb[$];
    exp_t e;
    bit   exp_vld, p_acc, p_cons, p_mul, done_now, exp_rdy, stray;
    int   mul_cnt;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.alu_op    = ALU_NOP;
    bus.src_a     = '0;
    bus.src_b     = '0;

    // Reset values
    #12;
    check("rst out_valid", bus.out_valid, 0);
    check("rst result", bus.result, 0);
    check("rst zero", bus.zero, 0);
    check("rst overflow", bus.overflow, 0);
    check("rst illegal", bus.illegal_op, 0);
    check("rst busy", bus.busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post-rst in_ready", bus.in_ready, 1);

    // Directed corner cases
    run_op("add_ovf", ALU_ADD, 32'h7fffffff, 32'h1, 32'h80000000, 0, 1, 0, 1);
    run_op("sub_zero", ALU_SUB, 32'd5, 32'd5, 32'h0, 1, 0, 0, 1);
    run_op("slt_neg", ALU_SLT, 32'hffffffff, 32'h1, 32'h1, 0, 0, 0, 1);
    run_op("illegal", 4'b0101, 32'h1234, 32'h5678, 32'h0, 1, 0, 1, 1);
    run_op("nor", ALU_NOR, 32'h0, 32'h0, 32'hffffffff, 0, 0, 0, 1);
    run_op("nop", ALU_NOP, 32'hdead, 32'hbeef, 32'h0, 1, 0, 0, 1);
    run_op("sub_ovf", ALU_SUB, 32'h80000000, 32'h1, 32'h7fffffff, 0, 1, 0, 1);
`ifdef ALU_MUL_EN
    run_op("mul", ALU_MUL, 32'd6, 32'd7, 32'd42, 0, 0, 0, MULC + 1);
`else
    run_op("mul_off", ALU_MUL, 32'd6, 32'd7, 32'd0, 1, 0, 1, 1);
`endif

    // Backpressure: hold a result for 5 cycles with a new request waiting
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.alu_op = ALU_ADD; bus.src_a = 32'd3; bus.src_b = 32'd4; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.alu_op = ALU_SUB; bus.src_a = 32'd10; bus.src_b = 32'd1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp in_ready", bus.in_ready, 0);
      check("bp out_valid", bus.out_valid, 1);
      check("bp result", bus.result, 7);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp release in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp new out_valid", bus.out_valid, 1);
    check("bp new result", bus.result, 9);
    @(posedge clk); #1;

    // Reset in the middle of a multiply
    bus.alu_op = ALU_MUL; bus.src_a = 32'd123; bus.src_b = 32'd456;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst out_valid", bus.out_valid, 0);
    check("midrst busy", bus.busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("midrst in_ready", bus.in_ready, 1);
    stray = 0;
    for (int k = 0; k < MULC + 8; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) stray = 1;
    end
    check("midrst no stray result", stray, 0);
    run_op("after_rst", ALU_XOR, 32'hf0f0f0f0, 32'hff00ff00, 32'h0ff00ff0, 0, 0, 0, 1);

    // Drain, then randomized stream against the scoreboard
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    exp_vld = 0; mul_cnt = 0; p_acc = 0; p_cons = 0; p_mul = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(posedge clk); #1;
      done_now = 0;
      if (mul_cnt > 0) begin
        mul_cnt--;
        if (mul_cnt == 0) done_now = 1;
      end
      if ((p_acc && !p_mul) || done_now) exp_vld = 1;
      else if (p_cons)                   exp_vld = 0;
      if (p_acc && p_mul) mul_cnt = MULC + 1;

      check("rnd out_valid", bus.out_valid, exp_vld);
      check("rnd busy", bus.busy, mul_cnt > 0);
      if (exp_vld) begin
        if (sb.size() == 0) begin
          check("rnd scoreboard empty", 1, 0);
        end else begin
          check("rnd result", bus.result, sb[0].res);
          check("rnd zero", bus.zero, sb[0].z);
          check("rnd overflow", bus.overflow, sb[0].o);
          check("rnd illegal", bus.illegal_op, sb[0].i);
        end
      end

      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 31))
        0:       bus.alu_op = ALU_MUL;
        1, 2, 3: bus.alu_op = 4'($urandom_range(0, 15));
        default: begin
          case ($urandom_range(0, 7))
            0: bus.alu_op = ALU_ADD;
            1: bus.alu_op = ALU_SUB;
            2: bus.alu_op = ALU_AND;
            3: bus.alu_op = ALU_OR;
            4: bus.alu_op = ALU_XOR;
            5: bus.alu_op = ALU_NOR;
            6: bus.alu_op = ALU_SLT;
            default: bus.alu_op = ALU_NOP;
          endcase
        end
      endcase
      bus.src_a = rand_opnd();
      bus.src_b = rand_opnd();
      #1;
      exp_rdy = (mul_cnt == 0) && (!exp_vld || bus.out_ready);
      check("rnd in_ready", bus.in_ready, exp_rdy);

      p_acc  = bus.in_valid && exp_rdy;
      p_cons = exp_vld && bus.out_ready;
      p_mul  = mul_code(bus.alu_op);
      if (p_cons && sb.size() > 0) void'(sb.pop_front());
      if (p_acc) begin
        e = ref_alu(bus.alu_op, bus.src_a, bus.src_b);
        sb.push_back(e);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
